// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner.
// Drives one column low at a time and samples the synchronised, active-low rows once per
// column step. A frame of four steps is classified as none/single/multi, and a
// debounce FSM turns stable single-key frames into a key code plus a one-clock valid pulse.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while a key is held).
module keypad_scan #(
    parameter int unsigned CLK_DIV      = 50000,
`ifdef KEY_REPEAT_EN
    parameter int unsigned REPEAT_SCANS = 100,
`endif
    parameter int unsigned DEBOUNCE     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] kb_row,
    output logic [3:0] kb_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] DebTarget = CntW'(DEBOUNCE);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
`ifdef KEY_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RepW-1:0] RepTarget = RepW'(REPEAT_SCANS);
`endif

    typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

    logic [3:0]      row_s1_q, row_s2_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      col_idx_q;
    logic [1:0]      hits_q, hits_new;
    logic [3:0]      pos_q, pos_new;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_down_q, key_down_d;
`ifdef KEY_REPEAT_EN
    logic [RepW-1:0] rep_q, rep_d, rep_inc;
`endif

    logic       tick, frame_end;
    logic [3:0] row_low;
    logic [2:0] n_low;
    logic [1:0] row_sel;
    logic       f_none, f_single;
    logic       accept, release_key;
    logic [3:0] accept_key;

    // Two-flop synchroniser for the asynchronous row inputs; idle level is all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= kb_row;
            row_s2_q <= row_s1_q;
        end
    end

    assign tick      = (div_q == DivLast);
    assign frame_end = tick && (col_idx_q == 2'd3);

    // Column-step divider and column rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
        end else if (tick) begin
            div_q     <= '0;
            col_idx_q <= col_idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign kb_col = ~(4'b0001 << col_idx_q);

    // Count low rows in the current column and remember the (last) low row index.
    always_comb begin
        row_low = ~row_s2_q;
        n_low   = 3'd0;
        row_sel = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) begin
                n_low   = n_low + 3'd1;
                row_sel = 2'(r);
            end
        end
    end

    // Merge this column into the frame tally: hits saturates at 2 (= multi).
    always_comb begin
        if (hits_q == 2'd2 || n_low >= 3'd2 || (hits_q == 2'd1 && n_low == 3'd1)) begin
            hits_new = 2'd2;
        end else if (hits_q == 2'd1 || n_low == 3'd1) begin
            hits_new = 2'd1;
        end else begin
            hits_new = 2'd0;
        end
        pos_new = (hits_q == 2'd0 && n_low == 3'd1) ? {row_sel, col_idx_q} : pos_q;
    end

    assign f_none   = (hits_new == 2'd0);
    assign f_single = (hits_new == 2'd1);

    // Frame tally registers, cleared at each frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q <= 2'd0;
            pos_q  <= 4'd0;
        end else if (tick) begin
            hits_q <= frame_end ? 2'd0 : hits_new;
            pos_q  <= frame_end ? 4'd0 : pos_new;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;
`ifdef KEY_REPEAT_EN
    assign rep_inc = rep_q + 1'b1;
`endif

    // Debounce FSM next-state and output logic; evaluated only at frame end.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        accept      = 1'b0;
        accept_key  = cand_q;
        release_key = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d       = rep_q;
`endif
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (f_single) begin
                        cand_d = pos_new;
                        cnt_d  = CntOne;
                        if (DEBOUNCE == 1) begin
                            accept     = 1'b1;
                            accept_key = pos_new;
                        end else begin
                            state_d = StDebounce;
                        end
                    end
                end
                StDebounce: begin
                    if (f_single && pos_new == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebTarget) accept = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StPressed: begin
                    if (f_none) begin
                        cnt_d = CntOne;
`ifdef KEY_REPEAT_EN
                        rep_d = '0;
`endif
                        if (DEBOUNCE == 1) release_key = 1'b1;
                        else               state_d     = StRelease;
                    end else begin
`ifdef KEY_REPEAT_EN
                        if (rep_inc == RepTarget) begin
                            key_valid_d = 1'b1;
                            rep_d       = '0;
                        end else begin
                            rep_d = rep_inc;
                        end
`endif
                    end
                end
                StRelease: begin
                    if (f_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebTarget) release_key = 1'b1;
                    end else begin
                        state_d = StPressed;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (accept) begin
            key_code_d  = accept_key;
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            state_d     = StPressed;
`ifdef KEY_REPEAT_EN
            rep_d       = '0;
`endif
        end
        if (release_key) begin
            key_down_d = 1'b0;
            state_d    = StIdle;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
`ifdef KEY_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with CLK_DIV=4, DEBOUNCE=3 (16-clock frames).
// A behavioural keypad pulls a row low when a pressed key's column is driven low.
module tb_keypad_scan;

    localparam int FrameClks = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] kb_row;
    logic [3:0] kb_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [15:0] key_mask = 16'h0000;

    int checks = 0;
    int errors = 0;

    keypad_scan #(
        .CLK_DIV      (4),
`ifdef KEY_REPEAT_EN
        .REPEAT_SCANS (5),
`endif
        .DEBOUNCE     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kb_row    (kb_row),
        .kb_col    (kb_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Keypad matrix model: key r*4+c shorts row r to column c.
    always_comb begin
        kb_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !kb_col[c]) kb_row[r] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          exp_pulses;
        logic        exp_down;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply a key mask for n whole frames (starting at a frame boundary) and count pulses.
    task automatic run_frames(input logic [15:0] mask, input int n, output int pulses);
        key_mask = mask;
        pulses   = 0;
        repeat (n * FrameClks) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid) pulses++;
        end
    endtask

    localparam logic [15:0] K0  = 16'h0001;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K10 = 16'h0400;
    localparam logic [15:0] K15 = 16'h8000;

    initial begin
        int p;
        int rep_pulses;
        string nm;

`ifdef KEY_REPEAT_EN
        rep_pulses = 4;
`else
        rep_pulses = 1;
`endif
        // mask, frames, pulses, down, code (cumulative sequence)
        vecs[0]  = '{K9,       2, 0, 1'b0, 4'd0};   // held, not yet debounced
        vecs[1]  = '{K9,       1, 1, 1'b1, 4'd9};   // 3rd frame accepts
        vecs[2]  = '{16'h0,    2, 0, 1'b1, 4'd9};   // release not yet debounced
        vecs[3]  = '{16'h0,    1, 0, 1'b0, 4'd9};   // 3rd empty frame releases
        vecs[4]  = '{K9,       1, 0, 1'b0, 4'd9};   // bounce: on 1
        vecs[5]  = '{16'h0,    1, 0, 1'b0, 4'd9};   // off 1
        vecs[6]  = '{K9,       2, 0, 1'b0, 4'd9};   // on 2
        vecs[7]  = '{16'h0,    1, 0, 1'b0, 4'd9};   // off 1
        vecs[8]  = '{K9,       2, 0, 1'b0, 4'd9};   // steady, 2 frames
        vecs[9]  = '{K9,       1, 1, 1'b1, 4'd9};   // 3rd steady frame accepts
        vecs[10] = '{16'h0,    3, 0, 1'b0, 4'd9};
        vecs[11] = '{K0 | K5,  4, 0, 1'b0, 4'd9};   // multi from idle ignored
        vecs[12] = '{16'h0,    1, 0, 1'b0, 4'd9};
        vecs[13] = '{K9,       3, 1, 1'b1, 4'd9};
        vecs[14] = '{K9 | K10, 2, 0, 1'b1, 4'd9};   // no rollover
        vecs[15] = '{K10,      2, 0, 1'b1, 4'd9};
        vecs[16] = '{16'h0,    2, 0, 1'b1, 4'd9};
        vecs[17] = '{16'h0,    1, 0, 1'b0, 4'd9};
        vecs[18] = '{K6,       3, 1, 1'b1, 4'd6};   // row1 col2
        vecs[19] = '{16'h0,    3, 0, 1'b0, 4'd6};
        vecs[20] = '{K15,      3, 1, 1'b1, 4'd15};  // row3 col3
        vecs[21] = '{16'h0,    3, 0, 1'b0, 4'd15};
        vecs[22] = '{K9,      20, rep_pulses, 1'b1, 4'd9};
        vecs[23] = '{16'h0,    3, 0, 1'b0, 4'd9};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset kb_col", int'(kb_col), 4'b1110);
        check("reset key_code", int'(key_code), 0);
        check("reset key_valid", int'(key_valid), 0);
        check("reset key_down", int'(key_down), 0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            run_frames(vecs[i].mask, vecs[i].frames, p);
            $sformat(nm, "vec%0d pulses", i);
            check(nm, p, vecs[i].exp_pulses);
            $sformat(nm, "vec%0d key_down", i);
            check(nm, int'(key_down), int'(vecs[i].exp_down));
            $sformat(nm, "vec%0d key_code", i);
            check(nm, int'(key_code), int'(vecs[i].exp_code));
        end

        // Exact press latency: pulse visible right after the 3rd frame-end edge, one clock wide.
        key_mask = K10;
        repeat (3 * FrameClks) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("latency key_valid", int'(key_valid), 1);
        check("latency key_down", int'(key_down), 1);
        check("latency key_code", int'(key_code), 10);
        @(posedge clk);
        @(negedge clk);
        check("pulse width key_valid", int'(key_valid), 0);

        // Reset mid-frame while a key is held and accepted.
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset kb_col", int'(kb_col), 4'b1110);
        check("midreset key_code", int'(key_code), 0);
        check("midreset key_valid", int'(key_valid), 0);
        check("midreset key_down", int'(key_down), 0);
        @(negedge clk);
        rst = 1'b0;
        run_frames(K10, 2, p);
        check("post-reset early pulses", p, 0);
        check("post-reset early key_down", int'(key_down), 0);
        run_frames(K10, 1, p);
        check("post-reset accept pulses", p, 1);
        check("post-reset accept key_code", int'(key_code), 10);
        run_frames(16'h0, 3, p);
        check("post-reset release key_down", int'(key_down), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
